// File: rtl/abacus_pkg.sv
// Shared types and constants for the ABACUS cache event conditioner.
package abacus_pkg;

  localparam int ABACUS_DEFAULT_LAT_W = 16;

  typedef enum logic {
    FILL_IDLE   = 1'b0,
    FILL_ACTIVE = 1'b1
  } fill_state_e;

endpackage

// File: rtl/abacus_edge_detect.sv
// Two-stage input sampler with a registered, enable-gated rising-edge pulse.
module abacus_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic level_i,
  output logic sample_o,
  output logic pulse_o
);

  logic sample_q;
  logic prev_q;
  logic pulse_q;

  // Sample stages keep running while disabled so re-enabling on a held level stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sample_q <= level_i;
      prev_q   <= sample_q;
      pulse_q  <= sample_q & ~prev_q & enable_i;
    end
  end

  assign sample_o = sample_q;
  assign pulse_o  = pulse_q;

endmodule

// File: rtl/abacus_cache_event_conditioner.sv
// Converts raw cache status levels into profiler event pulses and per-fill latency.
// Optional max-latency tracking is built when ABACUS_MAX_FILL_LATENCY_EN is defined.
module abacus_cache_event_conditioner
  import abacus_pkg::*;
#(
  parameter int   LAT_W          = ABACUS_DEFAULT_LAT_W,
  parameter logic STATUS_IS_MISS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear_max,
  input  logic             cache_request,
  input  logic             cache_status,
  input  logic             cache_line_fill_in_progress,
  output logic             request_pulse,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic             fill_cycle,
  output logic             fill_done,
  output logic [LAT_W-1:0] fill_latency,
  output logic             fill_latency_sat,
  output logic [LAT_W-1:0] max_fill_latency
);

  localparam logic [LAT_W-1:0] LAT_MAX = '1;

  logic s_req_unused;
  logic s_stat_unused;
  logic s_fill;
  logic stat_pulse;
  logic fill_rise_unused;

  abacus_edge_detect u_req (
    .clk(clk), .rst(rst), .enable_i(enable), .level_i(cache_request),
    .sample_o(s_req_unused), .pulse_o(request_pulse)
  );

  abacus_edge_detect u_stat (
    .clk(clk), .rst(rst), .enable_i(enable), .level_i(cache_status),
    .sample_o(s_stat_unused), .pulse_o(stat_pulse)
  );

  abacus_edge_detect u_fill (
    .clk(clk), .rst(rst), .enable_i(enable), .level_i(cache_line_fill_in_progress),
    .sample_o(s_fill), .pulse_o(fill_rise_unused)
  );

  assign miss_pulse = STATUS_IS_MISS ? stat_pulse : 1'b0;
  assign hit_pulse  = STATUS_IS_MISS ? 1'b0 : stat_pulse;

  fill_state_e      state_q, state_d;
  logic [LAT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             fill_cycle_q;
  logic             fill_done_q, fill_done_d;
  logic [LAT_W-1:0] fill_latency_q, fill_latency_d;
  logic             fill_sat_q, fill_sat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL_IDLE;
      count_q        <= '0;
      sat_q          <= 1'b0;
      fill_cycle_q   <= 1'b0;
      fill_done_q    <= 1'b0;
      fill_latency_q <= '0;
      fill_sat_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      sat_q          <= sat_d;
      fill_cycle_q   <= s_fill & enable;
      fill_done_q    <= fill_done_d;
      fill_latency_q <= fill_latency_d;
      fill_sat_q     <= fill_sat_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    sat_d          = sat_q;
    fill_done_d    = 1'b0;
    fill_latency_d = fill_latency_q;
    fill_sat_d     = fill_sat_q;
    case (state_q)
      FILL_IDLE: begin
        if (s_fill && enable) begin
          state_d = FILL_ACTIVE;
          count_d = LAT_W'(1);
          sat_d   = 1'b0;
        end
      end
      FILL_ACTIVE: begin
        if (!enable) begin
          // Abandoned fill: drop the partial count without reporting it.
          state_d = FILL_IDLE;
          count_d = '0;
          sat_d   = 1'b0;
        end else if (s_fill) begin
          if (count_q == LAT_MAX) sat_d = 1'b1;
          else                    count_d = count_q + 1'b1;
        end else begin
          state_d        = FILL_IDLE;
          fill_done_d    = 1'b1;
          fill_latency_d = count_q;
          fill_sat_d     = sat_q;
          count_d        = '0;
          sat_d          = 1'b0;
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  assign fill_cycle       = fill_cycle_q;
  assign fill_done        = fill_done_q;
  assign fill_latency     = fill_latency_q;
  assign fill_latency_sat = fill_sat_q;

`ifdef ABACUS_MAX_FILL_LATENCY_EN
  logic [LAT_W-1:0] max_q;

  // A completing fill wins over a coincident clear and seeds the new maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
    end else if (fill_done_q && (clear_max || (fill_latency_q > max_q))) begin
      max_q <= fill_latency_q;
    end else if (clear_max) begin
      max_q <= '0;
    end
  end

  assign max_fill_latency = max_q;
`else
  logic clear_max_unused;
  assign clear_max_unused = clear_max;
  assign max_fill_latency = '0;
`endif

endmodule

// File: tb/tb_abacus_cache_event_conditioner.sv
// Directed bench: icache (miss polarity), dcache (hit polarity) and a LAT_W=4 instance share stimulus.
module tb_abacus_cache_event_conditioner;

`ifdef ABACUS_MAX_FILL_LATENCY_EN
  localparam bit MAX_EN = 1'b1;
`else
  localparam bit MAX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, clear_max, req, stat, fill;

  logic i_req, i_hit, i_miss, i_fc, i_done, i_sat;
  logic [15:0] i_lat, i_max;
  logic d_req, d_hit, d_miss, d_fc, d_done, d_sat;
  logic [15:0] d_lat, d_max;
  logic s_req, s_hit, s_miss, s_fc, s_done, s_sat;
  logic [3:0] s_lat, s_max;

  abacus_cache_event_conditioner #(.LAT_W(16), .STATUS_IS_MISS(1'b1)) u_icache (
    .clk(clk), .rst(rst), .enable(enable), .clear_max(clear_max),
    .cache_request(req), .cache_status(stat), .cache_line_fill_in_progress(fill),
    .request_pulse(i_req), .hit_pulse(i_hit), .miss_pulse(i_miss), .fill_cycle(i_fc),
    .fill_done(i_done), .fill_latency(i_lat), .fill_latency_sat(i_sat), .max_fill_latency(i_max)
  );

  abacus_cache_event_conditioner #(.LAT_W(16), .STATUS_IS_MISS(1'b0)) u_dcache (
    .clk(clk), .rst(rst), .enable(enable), .clear_max(clear_max),
    .cache_request(req), .cache_status(stat), .cache_line_fill_in_progress(fill),
    .request_pulse(d_req), .hit_pulse(d_hit), .miss_pulse(d_miss), .fill_cycle(d_fc),
    .fill_done(d_done), .fill_latency(d_lat), .fill_latency_sat(d_sat), .max_fill_latency(d_max)
  );

  abacus_cache_event_conditioner #(.LAT_W(4), .STATUS_IS_MISS(1'b1)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .clear_max(clear_max),
    .cache_request(req), .cache_status(stat), .cache_line_fill_in_progress(fill),
    .request_pulse(s_req), .hit_pulse(s_hit), .miss_pulse(s_miss), .fill_cycle(s_fc),
    .fill_done(s_done), .fill_latency(s_lat), .fill_latency_sat(s_sat), .max_fill_latency(s_max)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Per-instance tallies: index 0 = icache, 1 = dcache, 2 = LAT_W=4.
  int c_req[3], c_hit[3], c_miss[3], c_fc[3], c_done[3], first_req[3];
  logic [31:0] lat[3];
  logic        sat[3];
  int cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 3; k++) begin
      c_req[k] = 0; c_hit[k] = 0; c_miss[k] = 0; c_fc[k] = 0; c_done[k] = 0;
      first_req[k] = 0; lat[k] = 32'hdead; sat[k] = 1'bx;
    end
    cyc = 0;
  endtask

  task automatic step(input int n);
    logic [2:0] vr, vh, vm, vf, vd;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      cyc++;
      vr = {s_req, d_req, i_req};
      vh = {s_hit, d_hit, i_hit};
      vm = {s_miss, d_miss, i_miss};
      vf = {s_fc, d_fc, i_fc};
      vd = {s_done, d_done, i_done};
      for (int k = 0; k < 3; k++) begin
        if (vr[k] === 1'b1) begin
          c_req[k]++;
          if (first_req[k] == 0) first_req[k] = cyc;
        end
        if (vh[k] === 1'b1) c_hit[k]++;
        if (vm[k] === 1'b1) c_miss[k]++;
        if (vf[k] === 1'b1) c_fc[k]++;
      end
      if (vd[0] === 1'b1) begin c_done[0]++; lat[0] = 32'(i_lat); sat[0] = i_sat; end
      if (vd[1] === 1'b1) begin c_done[1]++; lat[1] = 32'(d_lat); sat[1] = d_sat; end
      if (vd[2] === 1'b1) begin c_done[2]++; lat[2] = 32'(s_lat); sat[2] = s_sat; end
      $display("cyc=%0d req=%b stat=%b fill=%b en=%b | i:rq=%b ms=%b fc=%b dn=%b lat=%0d | d:hit=%b dn=%b | s:dn=%b lat=%0d sat=%b",
               cyc, req, stat, fill, enable, i_req, i_miss, i_fc, i_done, i_lat, d_hit, d_done, s_done, s_lat, s_sat);
    end
  endtask

  task automatic do_fill(input int n);
    fill = 1'b1;
    step(n);
    fill = 1'b0;
    step(4);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; clear_max = 1'b0; req = 1'b0; stat = 1'b0; fill = 1'b0;
    clr_counts();
    step(3);
    chk("rst_request_pulse", 32'(i_req), 0);
    chk("rst_fill_done", 32'(i_done), 0);
    chk("rst_fill_latency", 32'(i_lat), 0);
    chk("rst_fill_cycle", 32'(i_fc), 0);
    chk("rst_max", 32'(i_max), 0);
    rst = 1'b0;
    step(2);

    // Held request gives a single pulse two cycles after the rise
    enable = 1'b1;
    clr_counts();
    req = 1'b1; step(5); req = 1'b0; step(5);
    chk("req_count", c_req[0], 1);
    chk("req_latency", first_req[0], 2);
    chk("req_no_miss", c_miss[0], 0);
    chk("req_no_hit", c_hit[1], 0);
    chk("req_no_fill_cycle", c_fc[0], 0);

    // icache miss with a 5-cycle fill
    clr_counts();
    stat = 1'b1; fill = 1'b1; step(5); stat = 1'b0; fill = 1'b0; step(5);
    chk("miss_count", c_miss[0], 1);
    chk("miss_no_hit", c_hit[0], 0);
    chk("fill_cycle_5", c_fc[0], 5);
    chk("fill_done_5", c_done[0], 1);
    chk("fill_lat_5", lat[0], 5);
    chk("fill_sat_5", 32'(sat[0]), 0);
    chk("dcache_hit_polarity", c_hit[1], 1);
    chk("dcache_no_miss", c_miss[1], 0);

    // dcache: request held 6, then hit with a 4-cycle fill
    clr_counts();
    req = 1'b1; step(6); req = 1'b0;
    stat = 1'b1; fill = 1'b1; step(4); stat = 1'b0; fill = 1'b0; step(6);
    chk("d_req_count", c_req[1], 1);
    chk("d_hit_count", c_hit[1], 1);
    chk("d_done_count", c_done[1], 1);
    chk("d_lat_4", lat[1], 4);

    // 20-cycle fill saturates the 4-bit counter
    clr_counts();
    do_fill(20);
    chk("sat_done", c_done[2], 1);
    chk("sat_lat", lat[2], 15);
    chk("sat_flag", 32'(sat[2]), 1);
    chk("wide_lat_20", lat[0], 20);
    chk("wide_sat_0", 32'(sat[0]), 0);

    // Disable during a fill aborts it; a later fill counts normally
    clr_counts();
    fill = 1'b1; step(2); enable = 1'b0; step(1); fill = 1'b0; step(3); enable = 1'b1; step(3);
    chk("abort_no_done", c_done[0], 0);
    chk("abort_fill_cycle", c_fc[0], 1);
    clr_counts();
    do_fill(2);
    chk("after_abort_done", c_done[0], 1);
    chk("after_abort_lat", lat[0], 2);

    // Pulses suppressed while disabled, and enabling on a held level stays quiet
    clr_counts();
    enable = 1'b0; req = 1'b1; stat = 1'b1; step(4); enable = 1'b1; step(3); req = 1'b0; stat = 1'b0; step(2);
    chk("dis_req", c_req[0], 0);
    chk("dis_miss", c_miss[0], 0);

    // Back-to-back fills separated by one low cycle
    clr_counts();
    fill = 1'b1; step(3); fill = 1'b0; step(1); fill = 1'b1; step(2); fill = 1'b0; step(4);
    chk("b2b_done", c_done[0], 2);
    chk("b2b_last_lat", lat[0], 2);

    // Max latency tracking
    chk("max_before_clear", 32'(i_max), MAX_EN ? 20 : 0);
    chk("max_sat_inst", 32'(s_max), MAX_EN ? 15 : 0);
    clear_max = 1'b1; step(1); clear_max = 1'b0; step(1);
    chk("max_cleared", 32'(i_max), 0);
    do_fill(3); do_fill(7); do_fill(2);
    chk("max_3_7_2", 32'(i_max), MAX_EN ? 7 : 0);
    clear_max = 1'b1; step(1); clear_max = 1'b0; step(1);
    chk("max_clear2", 32'(i_max), 0);
    do_fill(4);
    chk("max_after_4", 32'(i_max), MAX_EN ? 4 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/abacus_cache_event_conditioner.md
Name: abacus_cache_event_conditioner

Overview:
Front-end stage between the core's raw cache status nets and the ABACUS cache profiler counters. It turns level-sensitive request, hit/miss and line-fill signals into single-cycle event pulses, and measures the latency of each line fill. One instance per cache: icache with a miss-polarity status net, dcache with a hit-polarity status net. Outputs feed the counter registers directly, so a held request counts once and fill latency counts in cycles.

Parameters:
LAT_W, 16, width of the per-fill latency counter and latency outputs (range 4..32).
STATUS_IS_MISS, 1'b1, 1 = cache_status high means miss (icache); 0 = high means hit (dcache).

Ports:
clk  in  1  clock (only clock)
rst  in  1  reset, synchronous, active-high
enable  in  1  profiling enable from the Wishbone control register
clear_max  in  1  single-cycle clear of max_fill_latency
cache_request  in  1  raw request level from core
cache_status  in  1  raw hit or miss level from core, polarity per STATUS_IS_MISS
cache_line_fill_in_progress  in  1  raw line-fill level from core
request_pulse  out  1  one cycle per request rising edge
hit_pulse  out  1  one cycle per hit event
miss_pulse  out  1  one cycle per miss event
fill_cycle  out  1  high for each registered cycle that a fill is in progress
fill_done  out  1  one cycle at the end of a completed fill
fill_latency  out  LAT_W  latency of the completed fill; valid only while fill_done is high
fill_latency_sat  out  1  qualifies fill_done: the latency counter saturated
max_fill_latency  out  LAT_W  largest fill_latency since reset or clear (only with the optional feature)

Behaviour:
- All inputs are registered once (s_req, s_stat, s_fill), then edge-detected against a second register stage. All outputs are registered. Input-to-pulse latency is 2 cycles.
- rst: all outputs, sample registers, FSM and counters go to 0 and the FSM goes to IDLE. The sample registers load 0, so a level already high when rst deasserts produces an edge.
- request_pulse = rising edge of s_req AND enable. A request held N cycles gives exactly 1 pulse.
- Status rising edge AND enable gives miss_pulse if STATUS_IS_MISS=1, otherwise hit_pulse. Only one of hit_pulse/miss_pulse can fire. request_pulse and the status pulse may fire in the same cycle.
- fill_cycle = s_fill AND enable, registered. It is high for exactly N cycles for an N-cycle fill.
- FSM states are IDLE and FILL:
  - IDLE -> FILL on s_fill high with enable. The latency counter loads 1.
  - FILL: the counter increments each cycle s_fill stays high, saturating at 2^LAT_W-1 and setting a sticky sat bit.
  - FILL -> IDLE on the first cycle s_fill is low. fill_done pulses for 1 cycle, with fill_latency = count and fill_latency_sat = sat bit; count and sat then clear.
  - FILL -> IDLE on enable low (disable mid-fill): no fill_done, counter cleared. A fill already high when enable rises starts counting from that cycle.
- enable low suppresses every pulse, but edge registers keep sampling. Enabling while a level is already high produces no pulse for that level.
- fill_latency holds its last value outside fill_done; consumers ignore it then.
- Back-to-back fills separated by 1 low cycle give two fill_done pulses. IDLE->FILL is taken in the same cycle as fill_done is issued, if s_fill rises again.

Optional Feature:
- Macro: ABACUS_MAX_FILL_LATENCY_EN.
- Defined: max_fill_latency updates to fill_latency on any fill_done where the new value is larger. It is cleared by rst or clear_max; if clear_max and fill_done coincide, it loads the new fill_latency.
- Undefined: the register is not built and max_fill_latency is tied to 0.

Decomposition:
- Package abacus_pkg: fill FSM state enum (FILL_IDLE, FILL_ACTIVE) and constant ABACUS_DEFAULT_LAT_W = 16.
- Sub-module abacus_edge_detect: registered rising-edge detector with enable gating, instantiated for request, status and fill.

Test Plan:
- enable=1, cache_request high 5 cycles -> request_pulse exactly 1 cycle, 2 cycles after the rise; other pulses 0.
- STATUS_IS_MISS=1, status and fill both high 5 cycles -> 1 miss_pulse, 5 fill_cycle, then fill_done with fill_latency=5, sat=0.
- STATUS_IS_MISS=0, request high 6 cycles, then status and fill high 4 cycles -> 1 request_pulse, 1 hit_pulse, fill_done with latency=4.
- LAT_W=4, fill high 20 cycles -> fill_done with fill_latency=15, fill_latency_sat=1.
- Fill high 3 cycles, enable dropped on cycle 2 -> no fill_done; a later 2-cycle fill with enable=1 gives latency=2.
- ABACUS_MAX_FILL_LATENCY_EN defined: fills of 3, 7, 2 -> max_fill_latency=7; clear_max -> 0; next fill of 4 -> 4.
